// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM with a memory-ready handshake and an illegal-opcode trap
module multicycle_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [3:0]       i_opcode,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_pc_write,
  output logic             o_pc_src,
  output logic             o_ir_write,
  output logic             o_reg_dst,
  output logic             o_alu_src,
  output logic [1:0]       o_alu_op,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_mem_to_reg,
  output logic             o_reg_write,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_instr_count,
  output logic [2:0]       o_state
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;
  localparam logic [3:0] OP_R = 4'b0110, OP_I = 4'b0001, OP_LS = 4'b0010, OP_SS = 4'b0011, OP_BEQ = 4'b0100;
  state_t           r_state, w_next;
  logic [3:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             w_retire, w_legal;
  logic             w_pc_write, w_pc_src, w_ir_write, w_reg_dst, w_alu_src;
  logic             w_mem_read, w_mem_write, w_mem_to_reg, w_reg_write;
  logic [1:0]       w_alu_op;
  assign w_legal = i_opcode == OP_R || i_opcode == OP_I || i_opcode == OP_LS ||
                   i_opcode == OP_SS || i_opcode == OP_BEQ;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_FETCH;
      r_op    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_op    <= (r_state == S_DECODE) ? i_opcode : r_op;
      r_cnt   <= w_retire ? r_cnt + CNT_W'(1) : r_cnt;
    end
  end
  always_comb begin
    w_next       = r_state;
    w_retire     = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_dst    = 1'b0;
    w_alu_src    = 1'b0;
    w_alu_op     = 2'b00;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_ir_write = i_mem_ready;
        w_pc_write = i_mem_ready;
        w_next     = i_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        w_alu_src  = r_op != OP_R && r_op != OP_BEQ;
        w_alu_op   = r_op == OP_R ? 2'b10 : r_op == OP_BEQ ? 2'b01 : 2'b00;
        w_pc_src   = r_op == OP_BEQ;
        w_pc_write = r_op == OP_BEQ && i_zero;
        w_retire   = r_op == OP_BEQ;
        w_next     = r_op == OP_BEQ ? S_FETCH : (r_op == OP_LS || r_op == OP_SS) ? S_MEM : S_WB;
      end
      S_MEM: begin
        w_alu_src   = 1'b1;
        w_mem_read  = r_op == OP_LS;
        w_mem_write = r_op == OP_SS;
        w_retire    = i_mem_ready && r_op == OP_SS;
        w_next      = !i_mem_ready ? S_MEM : r_op == OP_LS ? S_WB : S_FETCH;
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = r_op == OP_R;
        w_mem_to_reg = r_op == OP_LS;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end
  // Reset masks every control output combinationally, even FETCH's read request.
  assign o_pc_write    = w_pc_write   & ~i_rst;
  assign o_pc_src      = w_pc_src     & ~i_rst;
  assign o_ir_write    = w_ir_write   & ~i_rst;
  assign o_reg_dst     = w_reg_dst    & ~i_rst;
  assign o_alu_src     = w_alu_src    & ~i_rst;
  assign o_alu_op      = w_alu_op     & {2{~i_rst}};
  assign o_mem_read    = w_mem_read   & ~i_rst;
  assign o_mem_write   = w_mem_write  & ~i_rst;
  assign o_mem_to_reg  = w_mem_to_reg & ~i_rst;
  assign o_reg_write   = w_reg_write  & ~i_rst;
  assign o_halted      = (r_state == S_TRAP) & ~i_rst;
  assign o_instr_count = r_cnt;
  assign o_state       = r_state;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed checks of state sequencing, stalls, retire count, wrap, reset and trap
module tb_multicycle_sequencer;
  localparam int CW = 8;
  logic clk = 1'b0, rst, zero, ready;
  logic [3:0] opcode;
  logic pc_write, pc_src, ir_write, reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, halted;
  logic [1:0] alu_op;
  logic [CW-1:0] cnt;
  logic [2:0] state;
  logic [10:0] en;
  int checks = 0, errors = 0;
  multicycle_sequencer #(.CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_zero(zero), .i_mem_ready(ready),
    .o_pc_write(pc_write), .o_pc_src(pc_src), .o_ir_write(ir_write), .o_reg_dst(reg_dst),
    .o_alu_src(alu_src), .o_alu_op(alu_op), .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_mem_to_reg(mem_to_reg), .o_reg_write(reg_write), .o_halted(halted),
    .o_instr_count(cnt), .o_state(state)
  );
  always #5 clk = ~clk;
  assign en = {pc_write, pc_src, ir_write, reg_dst, alu_src, alu_op, mem_read, mem_write, mem_to_reg, reg_write};
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; zero = 1'b0; ready = 1'b1; opcode = 4'b0110;
    #3;
    chk("rst_state", 32'(state), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_halted", 32'(halted), 0);
    #4 rst = 1'b0;
    #1;
    chk("rel_fetch_en", 32'(en), 32'b10100_00_100_0);
    // R-type
    tick(); chk("r_dec_state", 32'(state), 1); chk("r_dec_en", 32'(en), 0);
    tick(); chk("r_exec_state", 32'(state), 2); chk("r_exec_en", 32'(en), 32'b00000_10_000_0);
    opcode = 4'b1111;
    tick(); chk("r_wb_state", 32'(state), 4); chk("r_wb_en", 32'(en), 32'b00010_00_000_1);
    chk("r_wb_cnt", 32'(cnt), 0);
    tick(); chk("r_ret_state", 32'(state), 0); chk("r_ret_cnt", 32'(cnt), 1);
    // LS with two stall cycles in MEM
    opcode = 4'b0010;
    tick(); tick(); chk("ls_exec_en", 32'(en), 32'b00001_00_000_0);
    ready = 1'b0;
    tick(); chk("ls_mem1_state", 32'(state), 3); chk("ls_mem1_en", 32'(en), 32'b00001_00_100_0);
    tick(); chk("ls_mem2_state", 32'(state), 3); chk("ls_mem2_rd", 32'(mem_read), 1);
    ready = 1'b1;
    #1 chk("ls_mem3_rd", 32'(mem_read), 1);
    tick(); chk("ls_wb_state", 32'(state), 4); chk("ls_wb_en", 32'(en), 32'b00000_00_001_1);
    tick(); chk("ls_ret_cnt", 32'(cnt), 2); chk("ls_ret_state", 32'(state), 0);
    // SS
    opcode = 4'b0011;
    tick(); tick(); tick();
    chk("ss_mem_en", 32'(en), 32'b00001_00_010_0);
    tick(); chk("ss_ret_state", 32'(state), 0); chk("ss_ret_cnt", 32'(cnt), 3);
    // BEQ taken then not taken
    opcode = 4'b0100; zero = 1'b1;
    tick(); tick(); chk("beq1_exec_en", 32'(en), 32'b11000_01_000_0);
    tick(); chk("beq1_ret_state", 32'(state), 0); chk("beq1_ret_cnt", 32'(cnt), 4);
    zero = 1'b0;
    tick(); tick(); chk("beq0_exec_en", 32'(en), 32'b01000_01_000_0);
    tick(); chk("beq0_ret_cnt", 32'(cnt), 5);
    // FETCH stall
    ready = 1'b0; #1;
    chk("fstall_en", 32'(en), 32'b00000_00_100_0);
    tick(); chk("fstall_state", 32'(state), 0);
    ready = 1'b1;
    // Reset during MEM of SS
    opcode = 4'b0011;
    tick(); tick(); tick();
    chk("ssr_mem_wr", 32'(mem_write), 1);
    rst = 1'b1; #1;
    chk("ssr_wr_drop", 32'(mem_write), 0);
    chk("ssr_state", 32'(state), 0);
    chk("ssr_cnt", 32'(cnt), 0);
    chk("ssr_en", 32'(en), 0);
    #1 rst = 1'b0;
    // I-type run to counter wrap
    opcode = 4'b0001;
    tick(); tick(); chk("i_exec_en", 32'(en), 32'b00001_00_000_0);
    tick(); chk("i_wb_en", 32'(en), 32'b00000_00_000_1);
    tick(); chk("i_ret_cnt", 32'(cnt), 1);
    for (int i = 0; i < 254 * 4; i++) tick();
    chk("i_cnt_255", 32'(cnt), 255);
    for (int i = 0; i < 4; i++) tick();
    chk("i_cnt_wrap", 32'(cnt), 0);
    chk("i_wrap_state", 32'(state), 0);
    // Illegal opcode traps
    opcode = 4'b1111;
    tick(); tick(); chk("trap_state", 32'(state), 7);
    for (int i = 0; i < 20; i++) begin
      chk("trap_hold", {20'd0, halted, state, en}, {20'd0, 1'b1, 3'd7, 11'd0});
      tick();
    end
    rst = 1'b1; #1;
    chk("trap_rst_state", 32'(state), 0);
    chk("trap_rst_halted", 32'(halted), 0);
    chk("trap_rst_cnt", 32'(cnt), 0);
    #1 rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
